dtw_word_packer: RTL and testbench

- Sits upstream of the DTW matcher and drives its start/word/finish interface.
- Accepts a stream of 8-bit character codes from the gesture classifier over a valid/ready handshake.
- Packs up to 15 characters into the 120-bit word format the matcher consumes, pulses start, and waits for finish.
- Presents the matched word downstream on a valid/ready result port, with an overflow flag and a watchdog timeout.

---
 rtl/dtw_word_packer_pkg.sv | 26 ++
 rtl/dtw_word_packer_if.sv | 33 +++
 rtl/dtw_word_packer.sv | 130 +++++++++++++
 tb/tb_dtw_word_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dtw_word_packer_pkg.sv
// Shared definitions for the DTW word packer and the matcher: word geometry,
// packer state encoding and the slot-to-bit-offset mapping both ends agree on.
package dtw_pkg;

    localparam int CHAR_W    = 8;
    localparam int MAX_CHARS = 15;
    localparam int WORD_W    = CHAR_W * MAX_CHARS;
    localparam int LEN_W     = 4;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LEN_W-1:0]  len_t;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_OUT     = 2'd3
    } pack_state_e;

    // Slot k of a packed word starts at bit CHAR_W*k.
    function automatic int unsigned slot(input int unsigned k);
        return k * 32'(CHAR_W);
    endfunction

endpackage

// File: rtl/dtw_word_packer_if.sv
// Character input, matcher start/finish and result port of the word packer.
// The packer uses the slave view; its environment uses the master view.
interface dtw_word_packer_if;
    import dtw_pkg::*;

    logic  i_char_valid;
    char_t i_char;
    logic  i_char_last;
    logic  o_char_ready;
    logic  o_dtw_start;
    word_t o_dtw_word;
    logic  i_dtw_finish;
    word_t i_dtw_word;
    logic  o_result_valid;
    word_t o_result_word;
    len_t  o_result_len;
    logic  o_overflow;
    logic  o_timeout;
    logic  i_result_ready;

    modport slave (
        input  i_char_valid, i_char, i_char_last, i_dtw_finish, i_dtw_word, i_result_ready,
        output o_char_ready, o_dtw_start, o_dtw_word, o_result_valid, o_result_word,
               o_result_len, o_overflow, o_timeout
    );

    modport master (
        output i_char_valid, i_char, i_char_last, i_dtw_finish, i_dtw_word, i_result_ready,
        input  o_char_ready, o_dtw_start, o_dtw_word, o_result_valid, o_result_word,
               o_result_len, o_overflow, o_timeout
    );

endinterface

// File: rtl/dtw_word_packer.sv
// Packs up to MAX_CHARS nonzero character codes into a matcher word, starts the
// matcher, waits (with a watchdog) for finish and holds the result until taken.
module dtw_word_packer
    import dtw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    dtw_word_packer_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    pack_state_e      state_q;
    word_t            buf_q;
    len_t             len_q;
    logic             ovf_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;
    logic             res_valid_q;
    word_t            res_word_q;
    logic             timeout_q;

    logic             ready_d;
    logic             accept_d;
    logic             store_d;
    len_t             len_d;
    logic             ovf_d;

    // Accept decode and the length/overflow a character would produce.
    always_comb begin
        ready_d  = (state_q == S_COLLECT) && !i_rst;
        accept_d = bus.i_char_valid && ready_d;
        store_d  = 1'b0;
        len_d    = len_q;
        ovf_d    = ovf_q;
        if (accept_d && (bus.i_char != char_t'(8'h00))) begin
            if (len_q < len_t'(MAX_CHARS)) begin
                store_d = 1'b1;
                len_d   = len_q + 4'd1;
            end else begin
                ovf_d   = 1'b1;
            end
        end else begin
            store_d = 1'b0;
        end
    end

    // Packer state machine with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_COLLECT;
            buf_q       <= '0;
            len_q       <= 4'd0;
            ovf_q       <= 1'b0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_word_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (accept_d) begin
                        if (store_d) begin
                            buf_q[slot(32'(len_q)) +: CHAR_W] <= bus.i_char;
                        end
                        len_q <= len_d;
                        ovf_q <= ovf_d;
                        if (bus.i_char_last) begin
                            if (len_d == 4'd0) begin
                                buf_q <= '0;
                                ovf_q <= 1'b0;
                            end else begin
                                state_q <= S_START;
                                start_q <= 1'b1;
                            end
                        end
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Finish takes priority over an expiring watchdog.
                    if (bus.i_dtw_finish) begin
                        res_word_q  <= bus.i_dtw_word;
                        timeout_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else if (cnt_q == CNT_LAST) begin
                        res_word_q  <= buf_q;
                        timeout_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.i_result_ready) begin
                        res_valid_q <= 1'b0;
                        buf_q       <= '0;
                        len_q       <= 4'd0;
                        ovf_q       <= 1'b0;
                        timeout_q   <= 1'b0;
                        state_q     <= S_COLLECT;
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    assign bus.o_char_ready   = ready_d;
    assign bus.o_dtw_start    = start_q;
    assign bus.o_dtw_word     = buf_q;
    assign bus.o_result_valid = res_valid_q;
    assign bus.o_result_word  = res_word_q;
    assign bus.o_result_len   = len_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_timeout      = timeout_q;

endmodule

// File: tb/tb_dtw_word_packer.sv
// Directed bench for dtw_word_packer: a matcher model drives finish, and expected
// results queued at stimulus time are compared when the result port presents them.
module tb_dtw_word_packer;
    import dtw_pkg::*;

    typedef struct packed {
        word_t word;
        len_t  len;
        logic  ovf;
        logic  to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    exp_t sb_q[$];

    dtw_word_packer_if bus ();

    dtw_word_packer #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_dtw_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input char_t c, input logic last);
        int n;
        bus.i_char_valid = 1'b1;
        bus.i_char       = c;
        bus.i_char_last  = last;
        n = 0;
        while (bus.o_char_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("char_ready_wait", 128'(bus.o_char_ready), 128'(1));
        @(posedge clk); #1;
        bus.i_char_valid = 1'b0;
        bus.i_char_last  = 1'b0;
        bus.i_char       = 8'h00;
    endtask

    // Called right after the last character is accepted.
    task automatic run_matcher(input word_t packed_exp, input word_t match, input int delay);
        check("start_pulse", 128'(bus.o_dtw_start), 128'(1));
        check("dtw_word", 128'(bus.o_dtw_word), 128'(packed_exp));
        repeat (delay) begin
            @(posedge clk); #1;
            check("start_low", 128'(bus.o_dtw_start), 128'(0));
            check("dtw_word_stable", 128'(bus.o_dtw_word), 128'(packed_exp));
        end
        bus.i_dtw_finish = 1'b1;
        bus.i_dtw_word   = match;
        @(posedge clk); #1;
        bus.i_dtw_finish = 1'b0;
        bus.i_dtw_word   = '0;
        check("result_latency", 128'(bus.o_result_valid), 128'(1));
    endtask

    task automatic get_result(input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (bus.o_result_valid !== 1'b1 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("result_valid", 128'(bus.o_result_valid), 128'(1));
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = '1;
        check("result_word", 128'(bus.o_result_word), 128'(e.word));
        check("result_len", 128'(bus.o_result_len), 128'(e.len));
        check("overflow", 128'(bus.o_overflow), 128'(e.ovf));
        check("timeout", 128'(bus.o_timeout), 128'(e.to));
        bus.i_result_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_result_ready = 1'b0;
        check("ready_after_hs", 128'(bus.o_char_ready), 128'(1));
        check("valid_after_hs", 128'(bus.o_result_valid), 128'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_char_ready"}, 128'(bus.o_char_ready), 128'(0));
        check({tag, "_start"}, 128'(bus.o_dtw_start), 128'(0));
        check({tag, "_dtw_word"}, 128'(bus.o_dtw_word), 128'(0));
        check({tag, "_valid"}, 128'(bus.o_result_valid), 128'(0));
        check({tag, "_res_word"}, 128'(bus.o_result_word), 128'(0));
        check({tag, "_len"}, 128'(bus.o_result_len), 128'(0));
        check({tag, "_ovf"}, 128'(bus.o_overflow), 128'(0));
        check({tag, "_to"}, 128'(bus.o_timeout), 128'(0));
    endtask

    initial begin
        word_t w;
        int    n;
        int    sc;
        word_t held;
        bus.i_char_valid   = 1'b0;
        bus.i_char         = 8'h00;
        bus.i_char_last    = 1'b0;
        bus.i_dtw_finish   = 1'b0;
        bus.i_dtw_word     = '0;
        bus.i_result_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        #1;
        check("ready_after_reset", 128'(bus.o_char_ready), 128'(1));

        // Basic word
        sc = start_cnt;
        sb_q.push_back('{word: 120'h4948, len: 4'd2, ovf: 1'b0, to: 1'b0});
        send_char(8'h48, 1'b0);
        send_char(8'h49, 1'b1);
        run_matcher(120'h4948, 120'h4948, 5);
        get_result(10);
        check("basic_one_start", 128'(start_cnt), 128'(sc + 1));

        // Overflow: 18 chars, only the first 15 packed
        w = '0;
        for (int k = 0; k < 15; k++) w[8*k +: 8] = 8'(k + 1);
        sb_q.push_back('{word: 120'hABCD, len: 4'd15, ovf: 1'b1, to: 1'b0});
        for (int k = 0; k < 18; k++) send_char(8'(k + 1), (k == 17) ? 1'b1 : 1'b0);
        run_matcher(w, 120'hABCD, 3);
        get_result(10);

        // Empty word and padding
        sc = start_cnt;
        send_char(8'h00, 1'b1);
        check("empty_ready", 128'(bus.o_char_ready), 128'(1));
        @(posedge clk); #1;
        check("empty_no_start", 128'(start_cnt), 128'(sc));
        check("empty_ready_hold", 128'(bus.o_char_ready), 128'(1));
        sb_q.push_back('{word: 120'h4241, len: 4'd2, ovf: 1'b0, to: 1'b0});
        send_char(8'h41, 1'b0);
        send_char(8'h00, 1'b0);
        send_char(8'h42, 1'b1);
        run_matcher(120'h4241, 120'h4241, 2);
        get_result(10);

        // Timeout: result valid 16 edges after S_WAIT is entered
        sb_q.push_back('{word: 120'h43, len: 4'd1, ovf: 1'b0, to: 1'b1});
        send_char(8'h43, 1'b1);
        check("to_start", 128'(bus.o_dtw_start), 128'(1));
        @(posedge clk); #1;
        n = 0;
        while (bus.o_result_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("timeout_edges", 128'(n), 128'(16));
        get_result(5);

        // Back-pressure: result held, characters stalled
        sb_q.push_back('{word: 120'h5555, len: 4'd2, ovf: 1'b0, to: 1'b0});
        send_char(8'h44, 1'b0);
        send_char(8'h45, 1'b1);
        run_matcher(120'h4544, 120'h5555, 1);
        held = bus.o_result_word;
        bus.i_char_valid = 1'b1;
        bus.i_char       = 8'h77;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid", 128'(bus.o_result_valid), 128'(1));
            check("bp_word", 128'(bus.o_result_word), 128'(120'h5555));
            check("bp_stable", 128'(bus.o_result_word), 128'(held));
            check("bp_char_ready", 128'(bus.o_char_ready), 128'(0));
            check("bp_len", 128'(bus.o_result_len), 128'(2));
        end
        bus.i_char_valid = 1'b0;
        bus.i_char       = 8'h00;
        get_result(5);

        // Reset while waiting for the matcher
        send_char(8'h46, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        sc = start_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_midreset", 128'(bus.o_char_ready), 128'(1));
        repeat (20) @(posedge clk);
        #1;
        check("no_start_after_reset", 128'(start_cnt), 128'(sc));
        check("no_valid_after_reset", 128'(bus.o_result_valid), 128'(0));
        check("dtw_word_after_reset", 128'(bus.o_dtw_word), 128'(0));
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
